regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_if.sv | 55 +++++
 rtl/regfile.sv | 165 ++++++++++++++++
 tb/tb_regfile.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_if.sv
// Register-file bus: decoder issue, ROB search, resolved operands and ROB commit.
// The regfile sits on the slave modport; the decoder/ROB side uses master.
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

interface regfile_if;
    // Misprediction flush from the ROB
    logic                  clear;

    // Decoder issue request
    logic                  dec_ready;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [`ROB_WIDTH-1:0] empty_rob_id;

    // ROB search for in-flight producers
    logic [`ROB_WIDTH-1:0] search_rob_id_1;
    logic [`ROB_WIDTH-1:0] search_rob_id_2;
    logic                  search_ready_1;
    logic                  search_ready_2;
    logic [31:0]           search_val_1;
    logic [31:0]           search_val_2;

    // Resolved operands for the RS and LSB
    logic [31:0]           val1;
    logic [31:0]           val2;
    logic                  has_dep1;
    logic                  has_dep2;
    logic [`ROB_WIDTH-1:0] dep1;
    logic [`ROB_WIDTH-1:0] dep2;

    // ROB commit
    logic                  commit_ready;
    logic [`ROB_WIDTH-1:0] commit_rob_id;
    logic [4:0]            commit_reg_id;
    logic [31:0]           commit_val;

    modport master (
        output clear, dec_ready, rs1, rs2, rd, empty_rob_id,
        output search_ready_1, search_ready_2, search_val_1, search_val_2,
        output commit_ready, commit_rob_id, commit_reg_id, commit_val,
        input  search_rob_id_1, search_rob_id_2,
        input  val1, val2, has_dep1, has_dep2, dep1, dep2
    );

    modport slave (
        input  clear, dec_ready, rs1, rs2, rd, empty_rob_id,
        input  search_ready_1, search_ready_2, search_val_1, search_val_2,
        input  commit_ready, commit_rob_id, commit_reg_id, commit_val,
        output search_rob_id_1, search_rob_id_2,
        output val1, val2, has_dep1, has_dep2, dep1, dep2
    );
endinterface

// File: rtl/regfile.sv
// Architectural register file with rename tags (32 x 32-bit, x0 hard-wired 0).
// Each register carries a busy bit and the ROB tag of its newest producer.
// Operands are resolved combinationally from the register, the ROB search
// result, or reported as a dependency on the producer tag.
// Optional feature: define RF_COMMIT_CNT_EN to add the commit_cnt output,
// a free-running count of committed non-x0 writes.
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

module regfile (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    regfile_if.slave    bus
`ifdef RF_COMMIT_CNT_EN
    ,
    output logic [31:0] commit_cnt
`endif
);

    localparam int RW = `ROB_WIDTH;

    // Current state of every register, gathered for combinational lookup
    logic [31:0]   rf_data [32];
    logic          rf_busy [32];
    logic [RW-1:0] rf_tag  [32];

    // Qualified per-cycle events; rdy_in low freezes everything
    logic issue_en;
    logic commit_en;
    logic flush_en;

    assign flush_en  = rdy_in && bus.clear;
    assign issue_en  = rdy_in && !bus.clear && bus.dec_ready;
    assign commit_en = rdy_in && bus.commit_ready;

    genvar gi;

    // Per-register storage; x0 is a constant zero that is never busy
    generate
        for (gi = 0; gi < 32; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign rf_data[gi] = '0;
                assign rf_busy[gi] = 1'b0;
                assign rf_tag[gi]  = '0;
            end else begin : g_live
                logic [31:0]   data_d, data_q;
                logic          busy_d, busy_q;
                logic [RW-1:0] tag_d,  tag_q;
                logic          issue_hit;
                logic          commit_hit;

                assign issue_hit  = issue_en  && (bus.rd == 5'(gi));
                assign commit_hit = commit_en && (bus.commit_reg_id == 5'(gi));

                // Commit writes the value; a newer issue to the same register
                // keeps it busy under the new tag; a flush drops the busy bit
                always_comb begin
                    data_d = data_q;
                    busy_d = busy_q;
                    tag_d  = tag_q;
                    if (commit_hit) begin
                        data_d = bus.commit_val;
                        if ((tag_q == bus.commit_rob_id) && !issue_hit) begin
                            busy_d = 1'b0;
                        end
                    end
                    if (flush_en) begin
                        busy_d = 1'b0;
                    end else if (issue_hit) begin
                        busy_d = 1'b1;
                        tag_d  = bus.empty_rob_id;
                    end
                end

                // State register; reset wins over any same-cycle update
                always_ff @(posedge clk_in) begin
                    if (rst_in) begin
                        data_q <= '0;
                        busy_q <= 1'b0;
                        tag_q  <= '0;
                    end else begin
                        data_q <= data_d;
                        busy_q <= busy_d;
                        tag_q  <= tag_d;
                    end
                end

                assign rf_data[gi] = data_q;
                assign rf_busy[gi] = busy_q;
                assign rf_tag[gi]  = tag_q;
            end
        end
    endgenerate

    // Operand ports gathered into arrays so both lanes share one resolver
    logic [4:0]    op_rs   [2];
    logic          op_srdy [2];
    logic [31:0]   op_sval [2];
    logic [31:0]   op_val  [2];
    logic          op_dep  [2];
    logic [RW-1:0] op_tag  [2];

    assign op_rs[0]   = bus.rs1;
    assign op_rs[1]   = bus.rs2;
    assign op_srdy[0] = bus.search_ready_1;
    assign op_srdy[1] = bus.search_ready_2;
    assign op_sval[0] = bus.search_val_1;
    assign op_sval[1] = bus.search_val_2;

    // Resolution uses pre-edge state, so a same-cycle issue with rd == rsN
    // still sees the previous producer
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            // Register value, forwarded ROB result, or a pending dependency
            always_comb begin
                op_tag[gi] = rf_tag[op_rs[gi]];
                op_val[gi] = rf_data[op_rs[gi]];
                op_dep[gi] = 1'b0;
                if ((op_rs[gi] != 5'd0) && rf_busy[op_rs[gi]]) begin
                    if (op_srdy[gi]) begin
                        op_val[gi] = op_sval[gi];
                    end else begin
                        op_val[gi] = '0;
                        op_dep[gi] = 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign bus.search_rob_id_1 = op_tag[0];
    assign bus.search_rob_id_2 = op_tag[1];
    assign bus.val1            = op_val[0];
    assign bus.val2            = op_val[1];
    assign bus.has_dep1        = op_dep[0];
    assign bus.has_dep2        = op_dep[1];
    assign bus.dep1            = op_tag[0];
    assign bus.dep2            = op_tag[1];

`ifdef RF_COMMIT_CNT_EN
    logic [31:0] cnt_d, cnt_q;

    // Count committed writes to x1..x31; flush does not touch it
    always_comb begin
        cnt_d = cnt_q;
        if (commit_en && (bus.commit_reg_id != 5'd0)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign commit_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic
// against an array-based model of the architectural/rename state.
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

module tb_regfile;
    localparam int RW = `ROB_WIDTH;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    always #5 clk_in = ~clk_in;

    regfile_if rf_if ();

`ifdef RF_COMMIT_CNT_EN
    logic [31:0] commit_cnt;
    regfile dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(rf_if),
                 .commit_cnt(commit_cnt));
`else
    regfile dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(rf_if));
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    logic [31:0]   m_reg  [32];
    logic          m_busy [32];
    logic [RW-1:0] m_tag  [32];
    logic [31:0]   m_cnt;

    function automatic logic [31:0] exp_val(input logic [4:0] rs, input logic srdy,
                                            input logic [31:0] sval);
        if (rs == 0) return 32'd0;
        if (!m_busy[rs]) return m_reg[rs];
        if (srdy) return sval;
        return 32'd0;
    endfunction

    function automatic logic exp_dep(input logic [4:0] rs, input logic srdy);
        return (rs != 0) && m_busy[rs] && !srdy;
    endfunction

    task automatic drive_idle();
        rst_in = 1'b0;
        rdy_in = 1'b1;
        rf_if.clear = 1'b0;
        rf_if.dec_ready = 1'b0;
        rf_if.rs1 = 5'd0;
        rf_if.rs2 = 5'd0;
        rf_if.rd = 5'd0;
        rf_if.empty_rob_id = '0;
        rf_if.search_ready_1 = 1'b0;
        rf_if.search_ready_2 = 1'b0;
        rf_if.search_val_1 = 32'd0;
        rf_if.search_val_2 = 32'd0;
        rf_if.commit_ready = 1'b0;
        rf_if.commit_rob_id = '0;
        rf_if.commit_reg_id = 5'd0;
        rf_if.commit_val = 32'd0;
    endtask

    // Clock edge: advance the model with the inputs applied this cycle
    task automatic step();
        logic issue;
        logic [4:0] cr;
        @(posedge clk_in);
        cr = rf_if.commit_reg_id;
        issue = rf_if.dec_ready && !rf_if.clear && (rf_if.rd != 0);
        if (rst_in) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] = 32'd0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
            m_cnt = 32'd0;
        end else if (rdy_in) begin
            if (rf_if.commit_ready && cr != 0) begin
                m_reg[cr] = rf_if.commit_val;
                m_cnt = m_cnt + 32'd1;
                if (m_tag[cr] == rf_if.commit_rob_id && !(issue && rf_if.rd == cr))
                    m_busy[cr] = 1'b0;
            end
            if (rf_if.clear) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (issue) begin
                m_busy[rf_if.rd] = 1'b1;
                m_tag[rf_if.rd]  = rf_if.empty_rob_id;
            end
        end
        $display("txn t=%0t rst=%b rdy=%b clr=%b iss=%b rd=%0d rob=%0d cmt=%b creg=%0d crob=%0d cval=%h",
                 $time, rst_in, rdy_in, rf_if.clear, rf_if.dec_ready, rf_if.rd,
                 rf_if.empty_rob_id, rf_if.commit_ready, cr, rf_if.commit_rob_id,
                 rf_if.commit_val);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_in = 1'b1;
        rdy_in = 1'b0;
        rf_if.dec_ready = 1'b1; rf_if.rd = 5'd9; rf_if.empty_rob_id = 3;
        step();
        drive_idle();
        rf_if.rs1 = 5'd5;
        #1;
        n_checks++;
        if (rf_if.val1 !== 32'd0 || rf_if.has_dep1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rs5 val1=%h dep=%b expected 0/0", rf_if.val1, rf_if.has_dep1);
        end
        for (int r = 0; r < 32; r++) begin
            rf_if.rs1 = 5'(r); rf_if.rs2 = 5'(r);
            #1;
            n_checks++;
            if (rf_if.val1 !== 32'd0 || rf_if.has_dep1 !== 1'b0 ||
                rf_if.val2 !== 32'd0 || rf_if.has_dep2 !== 1'b0 ||
                rf_if.search_rob_id_1 !== '0) begin
                n_fail++;
                $display("FAIL reset_all r=%0d val1=%h dep1=%b val2=%h dep2=%b tag=%0d expected zeros",
                         r, rf_if.val1, rf_if.has_dep1, rf_if.val2, rf_if.has_dep2,
                         rf_if.search_rob_id_1);
            end
        end
    endtask

    task automatic test_dependency();
        drive_idle();
        rf_if.dec_ready = 1'b1; rf_if.rd = 5'd3; rf_if.empty_rob_id = 2;
        step();
        drive_idle();
        rf_if.rs1 = 5'd3;
        #1;
        n_checks++;
        if (rf_if.has_dep1 !== 1'b1 || rf_if.dep1 !== RW'(2) || rf_if.search_rob_id_1 !== RW'(2)) begin
            n_fail++;
            $display("FAIL dep_busy has_dep1=%b dep1=%0d srch=%0d expected 1/2/2",
                     rf_if.has_dep1, rf_if.dep1, rf_if.search_rob_id_1);
        end
        rf_if.search_ready_1 = 1'b1; rf_if.search_val_1 = 32'h55;
        #1;
        n_checks++;
        if (rf_if.val1 !== 32'h55 || rf_if.has_dep1 !== 1'b0) begin
            n_fail++;
            $display("FAIL dep_forward val1=%h has_dep1=%b expected 55/0", rf_if.val1, rf_if.has_dep1);
        end
    endtask

    task automatic test_commit();
        drive_idle();
        rf_if.commit_ready = 1'b1; rf_if.commit_rob_id = 2;
        rf_if.commit_reg_id = 5'd3; rf_if.commit_val = 32'h1234;
        step();
        drive_idle();
        rf_if.rs1 = 5'd3;
        #1;
        n_checks++;
        if (rf_if.val1 !== 32'h1234 || rf_if.has_dep1 !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_match val1=%h has_dep1=%b expected 1234/0", rf_if.val1, rf_if.has_dep1);
        end
        rf_if.dec_ready = 1'b1; rf_if.rd = 5'd3; rf_if.empty_rob_id = 7;
        step();
        drive_idle();
        rf_if.commit_ready = 1'b1; rf_if.commit_rob_id = 1;
        rf_if.commit_reg_id = 5'd3; rf_if.commit_val = 32'h9999;
        step();
        drive_idle();
        rf_if.rs1 = 5'd3;
        #1;
        n_checks++;
        if (rf_if.has_dep1 !== 1'b1 || rf_if.dep1 !== RW'(7)) begin
            n_fail++;
            $display("FAIL commit_stale has_dep1=%b dep1=%0d expected 1/7", rf_if.has_dep1, rf_if.dep1);
        end
    endtask

    task automatic test_issue_commit();
        drive_idle();
        rf_if.dec_ready = 1'b1; rf_if.rd = 5'd4; rf_if.empty_rob_id = 5;
        step();
        drive_idle();
        rf_if.dec_ready = 1'b1; rf_if.rd = 5'd4; rf_if.empty_rob_id = 6;
        rf_if.commit_ready = 1'b1; rf_if.commit_rob_id = 5;
        rf_if.commit_reg_id = 5'd4; rf_if.commit_val = 32'hAA;
        step();
        drive_idle();
        rf_if.rs1 = 5'd4;
        #1;
        n_checks++;
        if (rf_if.has_dep1 !== 1'b1 || rf_if.dep1 !== RW'(6)) begin
            n_fail++;
            $display("FAIL issue_commit has_dep1=%b dep1=%0d expected 1/6", rf_if.has_dep1, rf_if.dep1);
        end
        // Same-cycle issue with rd == rs1 still reads the previous producer
        rf_if.rs1 = 5'd7; rf_if.dec_ready = 1'b1; rf_if.rd = 5'd7; rf_if.empty_rob_id = 3;
        #1;
        n_checks++;
        if (rf_if.has_dep1 !== 1'b0 || rf_if.val1 !== 32'd0) begin
            n_fail++;
            $display("FAIL same_cycle_read has_dep1=%b val1=%h expected 0/0", rf_if.has_dep1, rf_if.val1);
        end
        step();
        drive_idle();
        rf_if.rs2 = 5'd7;
        #1;
        n_checks++;
        if (rf_if.has_dep2 !== 1'b1 || rf_if.dep2 !== RW'(3)) begin
            n_fail++;
            $display("FAIL issue_after has_dep2=%b dep2=%0d expected 1/3", rf_if.has_dep2, rf_if.dep2);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 3; i++) begin
            drive_idle();
            rf_if.dec_ready = 1'b1; rf_if.rd = 5'(10 + i); rf_if.empty_rob_id = RW'(1 + i);
            step();
        end
        drive_idle();
        rf_if.clear = 1'b1;
        rf_if.dec_ready = 1'b1; rf_if.rd = 5'd13; rf_if.empty_rob_id = 4;
        rf_if.commit_ready = 1'b1; rf_if.commit_rob_id = 9;
        rf_if.commit_reg_id = 5'd11; rf_if.commit_val = 32'hBEEF;
        step();
        drive_idle();
        rf_if.rs1 = 5'd3; rf_if.rs2 = 5'd4;
        #1;
        n_checks++;
        if (rf_if.val1 !== 32'h9999 || rf_if.val2 !== 32'hAA ||
            rf_if.has_dep1 !== 1'b0 || rf_if.has_dep2 !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_values val1=%h val2=%h dep=%b%b expected 9999/aa/00",
                     rf_if.val1, rf_if.val2, rf_if.has_dep1, rf_if.has_dep2);
        end
        rf_if.rs1 = 5'd11; rf_if.rs2 = 5'd13;
        #1;
        n_checks++;
        if (rf_if.val1 !== 32'hBEEF || rf_if.has_dep1 !== 1'b0 || rf_if.has_dep2 !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_commit val1=%h dep=%b%b expected beef/00",
                     rf_if.val1, rf_if.has_dep1, rf_if.has_dep2);
        end
        for (int r = 0; r < 32; r++) begin
            rf_if.rs1 = 5'(r);
            #1;
            n_checks++;
            if (rf_if.has_dep1 !== 1'b0 || rf_if.val1 !== m_reg[r]) begin
                n_fail++;
                $display("FAIL clear_all r=%0d val1=%h dep=%b expected %h/0",
                         r, rf_if.val1, rf_if.has_dep1, m_reg[r]);
            end
        end
    endtask

    task automatic test_rdy_low();
        drive_idle();
        rf_if.dec_ready = 1'b1; rf_if.rd = 5'd20; rf_if.empty_rob_id = 2;
        step();
        drive_idle();
        rdy_in = 1'b0;
        rf_if.clear = 1'b1;
        rf_if.dec_ready = 1'b1; rf_if.rd = 5'd21; rf_if.empty_rob_id = 5;
        rf_if.commit_ready = 1'b1; rf_if.commit_rob_id = 2;
        rf_if.commit_reg_id = 5'd20; rf_if.commit_val = 32'h4242;
        step();
        rf_if.rs1 = 5'd20; rf_if.rs2 = 5'd21;
        rf_if.dec_ready = 1'b0; rf_if.commit_ready = 1'b0; rf_if.clear = 1'b0;
        #1;
        n_checks++;
        if (rf_if.has_dep1 !== 1'b1 || rf_if.dep1 !== RW'(2) ||
            rf_if.has_dep2 !== 1'b0 || rf_if.val2 !== 32'd0) begin
            n_fail++;
            $display("FAIL rdy_low dep1=%b/%0d dep2=%b val2=%h expected 1/2 0 0",
                     rf_if.has_dep1, rf_if.dep1, rf_if.has_dep2, rf_if.val2);
        end
        // x0 ignores both issue and commit
        drive_idle();
        rf_if.dec_ready = 1'b1; rf_if.rd = 5'd0; rf_if.empty_rob_id = 1;
        rf_if.commit_ready = 1'b1; rf_if.commit_reg_id = 5'd0; rf_if.commit_val = 32'hFFFF;
        step();
        drive_idle();
        #1;
        n_checks++;
        if (rf_if.val1 !== 32'd0 || rf_if.has_dep1 !== 1'b0) begin
            n_fail++;
            $display("FAIL x0 val1=%h has_dep1=%b expected 0/0", rf_if.val1, rf_if.has_dep1);
        end
    endtask

    task automatic test_reset_mid();
        drive_idle();
        rst_in = 1'b1;
        rf_if.dec_ready = 1'b1; rf_if.rd = 5'd9; rf_if.empty_rob_id = 4;
        rf_if.commit_ready = 1'b1; rf_if.commit_reg_id = 5'd8; rf_if.commit_val = 32'h77;
        step();
        drive_idle();
        rf_if.rs1 = 5'd9; rf_if.rs2 = 5'd8;
        #1;
        n_checks++;
        if (rf_if.has_dep1 !== 1'b0 || rf_if.val1 !== 32'd0 || rf_if.val2 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid dep1=%b val1=%h val2=%h expected 0/0/0",
                     rf_if.has_dep1, rf_if.val1, rf_if.val2);
        end
        rf_if.rs1 = 5'd4;
        #1;
        n_checks++;
        if (rf_if.val1 !== 32'd0 || rf_if.search_rob_id_1 !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_old val1=%h tag=%0d expected 0/0", rf_if.val1, rf_if.search_rob_id_1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [4:0] cr;
            drive_idle();
            rst_in = ($urandom_range(0, 99) == 0);
            rdy_in = ($urandom_range(0, 9) != 0);
            rf_if.clear = ($urandom_range(0, 19) == 0);
            rf_if.dec_ready = $urandom_range(0, 1);
            rf_if.rd = 5'($urandom_range(0, 7));
            rf_if.empty_rob_id = RW'($urandom);
            rf_if.rs1 = 5'($urandom_range(0, 7));
            rf_if.rs2 = 5'($urandom_range(0, 7));
            rf_if.search_ready_1 = $urandom_range(0, 1);
            rf_if.search_ready_2 = $urandom_range(0, 1);
            rf_if.search_val_1 = $urandom;
            rf_if.search_val_2 = $urandom;
            cr = 5'($urandom_range(0, 7));
            rf_if.commit_ready = $urandom_range(0, 1);
            rf_if.commit_reg_id = cr;
            rf_if.commit_rob_id = ($urandom_range(0, 1) == 1) ? m_tag[cr] : RW'($urandom);
            rf_if.commit_val = $urandom;
            #1;
            n_checks++;
            if (rf_if.search_rob_id_1 !== m_tag[rf_if.rs1] ||
                rf_if.val1 !== exp_val(rf_if.rs1, rf_if.search_ready_1, rf_if.search_val_1) ||
                rf_if.has_dep1 !== exp_dep(rf_if.rs1, rf_if.search_ready_1) ||
                (exp_dep(rf_if.rs1, rf_if.search_ready_1) && rf_if.dep1 !== m_tag[rf_if.rs1])) begin
                n_fail++;
                $display("FAIL rand_op1 c=%0d rs1=%0d val1=%h dep=%b tag=%0d expected %h/%b/%0d",
                         c, rf_if.rs1, rf_if.val1, rf_if.has_dep1, rf_if.dep1,
                         exp_val(rf_if.rs1, rf_if.search_ready_1, rf_if.search_val_1),
                         exp_dep(rf_if.rs1, rf_if.search_ready_1), m_tag[rf_if.rs1]);
            end
            n_checks++;
            if (rf_if.search_rob_id_2 !== m_tag[rf_if.rs2] ||
                rf_if.val2 !== exp_val(rf_if.rs2, rf_if.search_ready_2, rf_if.search_val_2) ||
                rf_if.has_dep2 !== exp_dep(rf_if.rs2, rf_if.search_ready_2) ||
                (exp_dep(rf_if.rs2, rf_if.search_ready_2) && rf_if.dep2 !== m_tag[rf_if.rs2])) begin
                n_fail++;
                $display("FAIL rand_op2 c=%0d rs2=%0d val2=%h dep=%b tag=%0d expected %h/%b/%0d",
                         c, rf_if.rs2, rf_if.val2, rf_if.has_dep2, rf_if.dep2,
                         exp_val(rf_if.rs2, rf_if.search_ready_2, rf_if.search_val_2),
                         exp_dep(rf_if.rs2, rf_if.search_ready_2), m_tag[rf_if.rs2]);
            end
`ifdef RF_COMMIT_CNT_EN
            n_checks++;
            if (commit_cnt !== m_cnt) begin
                n_fail++;
                $display("FAIL rand_cnt c=%0d commit_cnt=%0d expected %0d", c, commit_cnt, m_cnt);
            end
`endif
            step();
        end
    endtask

`ifdef RF_COMMIT_CNT_EN
    task automatic test_commit_cnt();
        drive_idle();
        rst_in = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            drive_idle();
            rf_if.commit_ready = 1'b1;
            rf_if.commit_val = 32'(i);
            rf_if.commit_reg_id = (i == 3) ? 5'd0 : 5'd1;
            if (i == 1) rf_if.clear = 1'b1;
            if (i == 4) rdy_in = 1'b0;
            if (i == 5) rf_if.commit_ready = 1'b0;
            step();
        end
        drive_idle();
        #1;
        n_checks++;
        if (commit_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL commit_cnt got %0d expected 3", commit_cnt);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = 32'd0; m_busy[i] = 1'b0; m_tag[i] = '0;
        end
        m_cnt = 32'd0;
        drive_idle();
        test_reset();
        test_dependency();
        test_commit();
        test_issue_commit();
        test_clear();
        test_rdy_low();
        test_reset_mid();
        test_random();
`ifdef RF_COMMIT_CNT_EN
        test_commit_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
